// File: rtl/layer_collector_pkg.sv
// Shared helpers for the output-layer collector.
package layer_collector_pkg;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int min_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/include.sv
// Project-wide sizing macros for the output layer of the network.
// Guarded so that any file may also provide its own fallback definition.
`ifndef numNeuronLayer4
`define numNeuronLayer4 10
`endif

`ifndef dataWidth
`define dataWidth 16
`endif

// File: rtl/layer_collector.sv
// Serial-to-parallel packer feeding the argmax stage: gathers numInput elements,
// then publishes them with a one-cycle valid pulse spaced at least holdCycles apart.
`ifndef numNeuronLayer4
`define numNeuronLayer4 10
`endif

`ifndef dataWidth
`define dataWidth 16
`endif

module layer_collector
    import layer_collector_pkg::*;
#(
    parameter int numInput   = `numNeuronLayer4,
    parameter int inputWidth = `dataWidth,
    parameter int holdCycles = numInput + 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [inputWidth-1:0]          i_data,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic [numInput*inputWidth-1:0] o_data,
    output logic                           o_data_valid,
    output logic                           o_drop
);

    localparam int CW = min_width(numInput);
    localparam int HW = min_width(holdCycles);
    localparam int VW = numInput * inputWidth;

    localparam logic [CW-1:0] CNT_LAST  = CW'(numInput - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(holdCycles - 1);

    logic [CW-1:0] cnt_r;
    logic [HW-1:0] hold_cnt_r;
    logic          full_r;
    logic [VW-1:0] capture_r;

    assign o_ready = !full_r && !i_rst;

    // Capture, holdoff and publish; o_data only changes on the emit edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r        <= '0;
            hold_cnt_r   <= '0;
            full_r       <= 1'b0;
            capture_r    <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_drop       <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_drop       <= i_valid && !o_ready;
            if (full_r && (hold_cnt_r == '0)) begin
                o_data       <= capture_r;
                o_data_valid <= 1'b1;
                full_r       <= 1'b0;
                hold_cnt_r   <= HOLD_LOAD;
            end else begin
                if (hold_cnt_r != '0) begin
                    hold_cnt_r <= hold_cnt_r - HW'(1);
                end
                // Collection of the next vector runs while the holdoff counts down.
                if (i_valid && !full_r) begin
                    capture_r[int'(cnt_r) * inputWidth +: inputWidth] <= i_data;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r  <= '0;
                        full_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_collector.sv
// Directed bench for layer_collector with a scoreboard tracking every emitted vector.
module tb_layer_collector;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int H  = 11;
    localparam int HL = 16;
    localparam int VW = N * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, valid = 1'b0;
    logic [W-1:0]  data = '0;
    logic          ready, ovalid, drop;
    logic [VW-1:0] odata;

    logic          rst_w = 1'b1, valid_w = 1'b0;
    logic [W-1:0]  data_w = '0;
    logic          ready_w, ovalid_w, drop_w;
    logic [VW-1:0] odata_w;

    layer_collector #(.numInput(N), .inputWidth(W), .holdCycles(H)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
        .o_ready(ready), .o_data(odata), .o_data_valid(ovalid), .o_drop(drop)
    );

    // Second instance with a longer holdoff so the WAIT state is reachable.
    layer_collector #(.numInput(N), .inputWidth(W), .holdCycles(HL)) u_dut_w (
        .i_clk(clk), .i_rst(rst_w), .i_data(data_w), .i_valid(valid_w),
        .o_ready(ready_w), .o_data(odata_w), .o_data_valid(ovalid_w), .o_drop(drop_w)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk_val(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: models acceptance, pending vectors, drops and held output data.
    logic          mon_on = 1'b0;
    int            cyc = 0;
    logic [VW-1:0] sb_q[$];
    logic [VW-1:0] acc_vec = '0;
    logic [VW-1:0] hold_exp = '0;
    int            acc_cnt = 0;
    int            last_pulse = 0;
    logic          m_full = 1'b0, prev_bad = 1'b0, had_pulse = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_on) begin
            chk_val("drop_model", VW'(drop), VW'(prev_bad));
            if (ovalid) begin
                chk_val("sb_pending", VW'(sb_q.size() != 0), VW'(1));
                if (sb_q.size() != 0) begin
                    hold_exp = sb_q.pop_front();
                    chk_val("sb_vector", odata, hold_exp);
                end
                if (had_pulse) chk_val("spacing", VW'((cyc - last_pulse) >= H), VW'(1));
                had_pulse  = 1'b1;
                last_pulse = cyc;
                m_full     = 1'b0;
            end else begin
                chk_val("hold_data", odata, hold_exp);
            end
            chk_val("ready_model", VW'(ready), VW'(!m_full && !rst));
            prev_bad = valid && m_full && !rst;
            if (rst) begin
                acc_cnt   = 0;
                m_full    = 1'b0;
                had_pulse = 1'b0;
                hold_exp  = '0;
                sb_q.delete();
            end else if (valid && !m_full) begin
                acc_vec[acc_cnt*W +: W] = data;
                acc_cnt++;
                if (acc_cnt == N) begin
                    sb_q.push_back(acc_vec);
                    m_full  = 1'b1;
                    acc_cnt = 0;
                end
            end
        end
    end

    logic [W-1:0]  sv [N] = '{16'd5, 16'd9, 16'd2, 16'd40, 16'd1, 16'd0, 16'd7, 16'd3, 16'd8, 16'd6};
    logic [VW-1:0] exp_v;
    logic [W-1:0]  best_v;
    int            best, idx, np, nd, nboth, npw, n;
    int            pc [2];
    logic          go;

    initial begin
        // Reset
        tick;
        mon_on = 1'b1;
        tick;
        chk_val("rst_data", odata, '0);
        chk_val("rst_valid", VW'(ovalid), '0);
        chk_val("rst_drop", VW'(drop), '0);
        chk_val("rst_ready", VW'(ready), '0);
        rst = 1'b0;
        rst_w = 1'b0;
        #1;
        chk_val("ready_after_rst", VW'(ready), VW'(1));

        // Single vector: argmax lands on element 3 (value 40)
        exp_v = '0;
        for (int k = 0; k < N; k++) begin
            valid = 1'b1;
            data  = sv[k];
            exp_v[k*W +: W] = sv[k];
            tick;
        end
        valid = 1'b0;
        chk_val("single_t1_valid", VW'(ovalid), '0);
        chk_val("single_t1_ready", VW'(ready), '0);
        tick;
        chk_val("single_t2_valid", VW'(ovalid), VW'(1));
        chk_val("single_elem3", VW'(odata[63:48]), VW'(40));
        chk_val("single_vec", odata, exp_v);
        chk_val("single_t2_ready", VW'(ready), VW'(1));
        best = 0;
        best_v = odata[W-1:0];
        for (int k = 1; k < N; k++) begin
            if (odata[k*W +: W] > best_v) begin
                best_v = odata[k*W +: W];
                best   = k;
            end
        end
        chk_val("argmax", VW'(best), VW'(3));
        tick;
        chk_val("single_pulse_len", VW'(ovalid), '0);

        // Holding across idle cycles
        np = 0;
        repeat (20) begin
            tick;
            if (ovalid) np++;
        end
        chk_val("idle_no_pulse", VW'(np), '0);
        chk_val("idle_hold", odata, exp_v);

        // Back-to-back: offer whenever ready
        idx = 0; np = 0; nd = 0; pc[0] = 0; pc[1] = 0;
        exp_v = '0;
        for (int k = 0; k < N; k++) exp_v[k*W +: W] = W'(32'hC000 + 3 * k);
        for (int i = 0; i < 60 && np < 2; i++) begin
            go    = ready && (idx < 2 * N);
            valid = go;
            data  = !go ? '0 : (idx < N) ? W'(32'h1000 + idx) : W'(32'hC000 + 3 * (idx - N));
            tick;
            if (go) idx++;
            if (ovalid) begin
                pc[np] = i;
                np++;
            end
            if (drop) nd++;
        end
        valid = 1'b0;
        chk_val("b2b_pulses", VW'(np), VW'(2));
        chk_val("b2b_spacing", VW'(pc[1] - pc[0]), VW'(H));
        chk_val("b2b_drops", VW'(nd), '0);
        chk_val("b2b_second_vec", odata, exp_v);

        // Overrun: i_valid held high with a counting pattern
        np = 0; nd = 0; nboth = 0;
        for (int i = 0; i < 33; i++) begin
            valid = 1'b1;
            data  = W'(32'h0200 + i);
            tick;
            if (ovalid) np++;
            if (drop) nd++;
            if (ovalid && drop) nboth++;
        end
        valid = 1'b0;
        exp_v = '0;
        for (int k = 0; k < N; k++) exp_v[k*W +: W] = W'(32'h0200 + 22 + k);
        chk_val("overrun_pulses", VW'(np), VW'(3));
        chk_val("overrun_drops", VW'(nd), VW'(3));
        chk_val("overrun_coincide", VW'(nboth), VW'(3));
        chk_val("overrun_last_vec", odata, exp_v);

        // Reset mid-collection
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1;
            data  = W'(32'h0300 + k);
            tick;
        end
        valid = 1'b0;
        chk_val("partial_hold", odata, exp_v);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_val("midrst_data", odata, '0);
        exp_v = '0;
        for (int k = 0; k < N; k++) begin
            valid = 1'b1;
            data  = W'(100 + k);
            exp_v[k*W +: W] = W'(100 + k);
            tick;
        end
        valid = 1'b0;
        chk_val("midrst_t1_valid", VW'(ovalid), '0);
        chk_val("midrst_t1_data", odata, '0);
        tick;
        chk_val("midrst_t2_valid", VW'(ovalid), VW'(1));
        chk_val("midrst_vec", odata, exp_v);
        chk_val("midrst_lsb", VW'(odata[15:0]), VW'(100));

        // Longer holdoff instance: vector X, then Y parked in WAIT and reset
        exp_v = '0;
        for (int k = 0; k < N; k++) begin
            valid_w = 1'b1;
            data_w  = W'(32'h0A00 + k);
            exp_v[k*W +: W] = W'(32'h0A00 + k);
            tick;
        end
        valid_w = 1'b0;
        chk_val("w_x_t1_valid", VW'(ovalid_w), '0);
        tick;
        chk_val("w_x_t2_valid", VW'(ovalid_w), VW'(1));
        chk_val("w_x_vec", odata_w, exp_v);
        for (int k = 0; k < N; k++) begin
            valid_w = 1'b1;
            data_w  = W'(32'h0B00 + k);
            tick;
        end
        valid_w = 1'b0;
        chk_val("w_wait_ready", VW'(ready_w), '0);
        chk_val("w_wait_valid", VW'(ovalid_w), '0);
        tick;
        tick;
        chk_val("w_wait_still", VW'(ovalid_w), '0);
        rst_w = 1'b1;
        tick;
        rst_w = 1'b0;
        #1;
        chk_val("w_rst_data", odata_w, '0);
        chk_val("w_rst_ready", VW'(ready_w), VW'(1));
        npw = 0;
        repeat (12) begin
            tick;
            if (ovalid_w) npw++;
        end
        chk_val("w_no_pending_pulse", VW'(npw), '0);
        chk_val("w_idle_data", odata_w, '0);

        exp_v = '0;
        for (int k = 0; k < N; k++) begin
            valid_w = 1'b1;
            data_w  = W'(32'h0D00 + k);
            exp_v[k*W +: W] = W'(32'h0D00 + k);
            tick;
        end
        valid_w = 1'b0;
        chk_val("w_z_t1_valid", VW'(ovalid_w), '0);
        tick;
        chk_val("w_z_t2_valid", VW'(ovalid_w), VW'(1));
        chk_val("w_z_vec", odata_w, exp_v);

        // Next vector must wait out the full holdoff of HL cycles
        for (int k = 0; k < N; k++) begin
            valid_w = 1'b1;
            data_w  = W'(32'h0E00 + k);
            tick;
        end
        valid_w = 1'b0;
        n = 0;
        while (!ovalid_w && n < 20) begin
            tick;
            n++;
        end
        chk_val("w_spacing", VW'(N + n), VW'(HL));
        chk_val("w_z_held", VW'(odata_w[15:0]), VW'(16'h0E00));

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
